clk_div_bank: RTL and testbench



---
 rtl/clk_div_bank.sv | 113 +++++++++++
 tb/tb_clk_div_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of N_CH independent programmable clock dividers.
// Each channel owns a counter, an active divisor and a shadow divisor.
// A new divisor takes effect on the period boundary, or right away when the
// channel is disabled or stopped. All outputs come straight from flops.

module clk_div_ch #(
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  output logic             clk_out,
  output logic             tick
);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             live;

  // Next-state: shadow load, counting, wrap-time divisor swap, idle/stop handling.
  // Outputs are derived from the next count so they line up with cnt after the edge.
  always_comb begin
    pend_d = wr ? wr_div : pend_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    // >= rather than == keeps the counter bounded even if cnt ever exceeds D-1
    wrap   = (cnt_q >= act_q - ONE);
    if (act_q < TWO) begin
      // stopped: keep pulling the shadow in so a valid write restarts cleanly
      cnt_d = '0;
      act_d = pend_q;
    end else if (!en) begin
      // frozen; a pending divisor is applied now and the period restarts from 0
      if (pend_q != act_q) begin
        act_d = pend_q;
        cnt_d = '0;
      end
    end else if (wrap) begin
      // pend_d forwards a write landing on the wrap cycle
      cnt_d = '0;
      act_d = pend_d;
    end else begin
      cnt_d = cnt_q + ONE;
    end
    live   = (act_d >= TWO);
    clk_d  = live && (cnt_d >= (act_d >> 1));
    tick_d = live && en && (cnt_d == act_d - ONE);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= RST_D;
      pend_q <= RST_D;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
endmodule

module clk_div_bank #(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 10,
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [N_CH-1:0]  en,
  input  logic             wr_en,
  input  logic [CW-1:0]    wr_ch,
  input  logic [WIDTH-1:0] wr_div,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);
  // One divider per channel; an out-of-range wr_ch matches no channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic wr_hit;
    assign wr_hit = wr_en && (wr_ch == CW'(i));
    clk_div_ch #(
      .WIDTH    (WIDTH),
      .RESET_DIV(RESET_DIV)
    ) u_ch (
      .clk    (CLK),
      .rst_n  (RSTn),
      .en     (en[i]),
      .wr     (wr_hit),
      .wr_div (wr_div),
      .clk_out(clk_out[i]),
      .tick   (tick[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (N_CH=2, WIDTH=16, RESET_DIV=10).
// Per-cycle vectors hold inputs applied before an edge and outputs expected after it.

module tb_clk_div_bank;
  logic        CLK;
  logic        RSTn;
  logic [1:0]  en;
  logic        wr_en;
  logic        wr_ch;
  logic [15:0] wr_div;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rstn;
    logic [1:0]  en;
    logic        wr_en;
    logic        wr_ch;
    logic [15:0] wr_div;
    logic [1:0]  eclk;
    logic [1:0]  etick;
  } vec_t;

  vec_t tbl[$];

  clk_div_bank #(.N_CH(2), .WIDTH(16), .RESET_DIV(10)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .clk_out(clk_out),
    .tick   (tick)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input int rstn, input int e, input int we, input int ch,
                     input int d, input int c, input int t);
    vec_t v;
    v.rstn   = 1'(rstn);
    v.en     = 2'(e);
    v.wr_en  = 1'(we);
    v.wr_ch  = 1'(ch);
    v.wr_div = 16'(d);
    v.eclk   = 2'(c);
    v.etick  = 2'(t);
    tbl.push_back(v);
  endtask

  // After the k-th edge since reset release with D=10 on both channels.
  task automatic chk_d10(input string nm, input int k);
    logic [1:0] ec, et;
    ec = ((k % 10) >= 5) ? 2'b11 : 2'b00;
    et = ((k % 10) == 9) ? 2'b11 : 2'b00;
    chk($sformatf("%s_clk_k%0d", nm, k), clk_out, ec);
    chk($sformatf("%s_tick_k%0d", nm, k), tick, et);
  endtask

  initial begin
    // ---- vector table: rstn, en, wr_en, wr_ch, wr_div, exp clk_out, exp tick
    // divisor 7 written to ch1 at cnt=3; ch1 finishes 10, then runs 7 (high 4/low 3)
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00);
    add(1,3,1,1,7,'b00,'b00);
    add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b00);
    add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b11);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b10,'b00); add(1,3,0,0,0,'b10,'b00); add(1,3,0,0,0,'b11,'b00);
    add(1,3,0,0,0,'b11,'b10); add(1,3,0,0,0,'b01,'b00); add(1,3,0,0,0,'b01,'b00);
    add(1,3,0,0,0,'b01,'b01); add(1,3,0,0,0,'b10,'b00); add(1,3,0,0,0,'b10,'b00);
    add(1,3,0,0,0,'b10,'b00); add(1,3,0,0,0,'b10,'b10); add(1,3,0,0,0,'b00,'b00);
    // reset, then ch0 writes 6 at cnt=7 and 4 at cnt=9: last write wins, forwarded at wrap
    add(0,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b00);
    add(1,3,0,0,0,'b11,'b00); add(1,3,1,0,6,'b11,'b00); add(1,3,0,0,0,'b11,'b11);
    add(1,3,1,0,4,'b00,'b00); add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b01,'b00);
    add(1,3,0,0,0,'b01,'b01); add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b10,'b00);
    add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b01); add(1,3,0,0,0,'b10,'b00);
    add(1,3,0,0,0,'b10,'b10); add(1,3,0,0,0,'b01,'b00);
    // reset, then en[0] low at cnt=6 for 5 edges; ch0 ticks 3 edges after re-enable
    add(0,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b00);
    add(1,2,0,0,0,'b11,'b00); add(1,2,0,0,0,'b11,'b00); add(1,2,0,0,0,'b11,'b10);
    add(1,2,0,0,0,'b01,'b00); add(1,2,0,0,0,'b01,'b00);
    add(1,3,0,0,0,'b01,'b00); add(1,3,0,0,0,'b01,'b00); add(1,3,0,0,0,'b01,'b01);
    add(1,3,0,0,0,'b10,'b00);
    // reset, ch0 gets D=1 (stops after wrap), then D=3 restarts with high 2/low 1
    add(0,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,1,0,1,'b00,'b00); add(1,3,0,0,0,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b00);
    add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b11);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b00,'b00); add(1,3,1,0,3,'b00,'b00);
    add(1,3,0,0,0,'b00,'b00); add(1,3,0,0,0,'b01,'b00); add(1,3,0,0,0,'b11,'b01);
    add(1,3,0,0,0,'b10,'b00); add(1,3,0,0,0,'b11,'b00); add(1,3,0,0,0,'b11,'b01);
    add(1,3,0,0,0,'b10,'b10); add(1,3,0,0,0,'b01,'b00);

    // ---- reset state and the basic D=10 run on both channels
    CLK    = 1'b0;
    RSTn   = 1'b1;
    en     = 2'b00;
    wr_en  = 1'b0;
    wr_ch  = 1'b0;
    wr_div = 16'd0;
    #1 RSTn = 1'b0;
    en = 2'b11;
    #1;
    chk("rst_clk_async", clk_out, 2'b00);
    chk("rst_tick_async", tick, 2'b00);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("rst_clk", clk_out, 2'b00);
      chk("rst_tick", tick, 2'b00);
    end
    RSTn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      chk_d10("d10", k);
    end

    // ---- table sequences
    for (int r = 0; r < tbl.size(); r++) begin
      RSTn   = tbl[r].rstn;
      en     = tbl[r].en;
      wr_en  = tbl[r].wr_en;
      wr_ch  = tbl[r].wr_ch;
      wr_div = tbl[r].wr_div;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_clk", r), clk_out, tbl[r].eclk);
      chk($sformatf("vec%0d_tick", r), tick, tbl[r].etick);
    end
    RSTn  = 1'b1;
    en    = 2'b11;
    wr_en = 1'b0;

    // ---- asynchronous reset mid-period, divisors return to 10
    @(posedge CLK); #1;
    chk("pre_arst_clk", clk_out, 2'b01);
    chk("pre_arst_tick", tick, 2'b01);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_clk", clk_out, 2'b00);
    chk("arst_tick", tick, 2'b00);
    @(posedge CLK); #1;
    chk("arst_hold_clk", clk_out, 2'b00);
    RSTn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CLK); #1;
      chk_d10("post_arst", k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
